// File: rtl/text_pkg.sv
// Shared definitions for the text ROM arbiter and its renderers.
// Holds ROM latency, per-image word indices and the read tag type.
package text_pkg;

  localparam int TEXT_ROM_LATENCY = 2;
  localparam int TEXT_IDX_W       = 3;

  // Word indices in the score panel image
  localparam int WORD_SCORE = 0;
  localparam int WORD_LEVEL = 1;
  localparam int WORD_LINES = 2;
  localparam int WORD_NEXT  = 3;
  localparam int WORD_HOLD  = 4;

  // Word indices in the menu image
  localparam int WORD_RESUME = 0;
  localparam int WORD_QUIT   = 1;
  localparam int WORD_PLAY   = 2;
  localparam int WORD_AGAIN  = 3;

  // Word indices in the banner image
  localparam int WORD_START     = 0;
  localparam int WORD_PAUSED    = 1;
  localparam int WORD_GAME_OVER = 2;

  typedef struct packed {
    logic                  valid;
    logic [TEXT_IDX_W-1:0] index;
  } text_tag_t;

endpackage

// File: rtl/arb_pick.sv
// Combinational priority picker starting its search at a pointer.
// Returns a one-hot winner, its encoded index and an any-winner flag.
module arb_pick
  import text_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0]          req_i,
  input  logic [TEXT_IDX_W-1:0] start_i,
  output logic [N-1:0]          gnt_o,
  output logic [TEXT_IDX_W-1:0] idx_o,
  output logic                  any_o
);

  // Scan N slots from start_i, wrapping modulo N, first hit wins
  always_comb begin
    int j;
    logic found;
    j     = 0;
    found = 1'b0;
    gnt_o = '0;
    idx_o = '0;
    for (int k = 0; k < N; k++) begin
      j = int'(start_i) + k;
      if (j >= N) j = j - N;
      if (!found && req_i[j]) begin
        found    = 1'b1;
        gnt_o[j] = 1'b1;
        idx_o    = TEXT_IDX_W'(j);
      end
    end
    any_o = found;
  end

endmodule

// File: rtl/text_rom_arbiter.sv
// Shares one glyph ROM port among NUM_REQ text renderers.
// Round-robin when TEXT_ARB_RR_EN is defined, else fixed priority.
module text_rom_arbiter
  import text_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int ADDR_WIDTH  = 15,
  parameter int ROM_LATENCY = TEXT_ROM_LATENCY,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                          clk_in,
  input  logic                          rst_in,
  input  logic [NUM_REQ-1:0]            req_valid_in,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr_in,
  output logic [NUM_REQ-1:0]            grant_out,
  output logic [ADDR_WIDTH-1:0]         rom_addr_out,
  input  logic                          rom_data_in,
  output logic [NUM_REQ-1:0]            rsp_valid_out,
  output logic [NUM_REQ-1:0]            rsp_data_out,
  output logic [CNT_WIDTH-1:0]          conflict_count_out
);

  logic [NUM_REQ-1:0]    pick_oh;
  logic [TEXT_IDX_W-1:0] pick_idx;
  logic                  pick_any;
  logic [TEXT_IDX_W-1:0] start;
  logic [ADDR_WIDTH-1:0] pick_addr;
  logic                  multi;

  logic [NUM_REQ-1:0]    grant_q;
  logic [TEXT_IDX_W-1:0] idx_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  text_tag_t             tag_q [ROM_LATENCY];
  text_tag_t             last;
  logic [NUM_REQ-1:0]    rsp_q;
  logic [NUM_REQ-1:0]    rsp_valid_d;
  logic [NUM_REQ-1:0]    rsp_data_d;
  logic [CNT_WIDTH-1:0]  cnt_q;

  arb_pick #(
    .N(NUM_REQ)
  ) u_pick (
    .req_i  (req_valid_in),
    .start_i(start),
    .gnt_o  (pick_oh),
    .idx_o  (pick_idx),
    .any_o  (pick_any)
  );

`ifdef TEXT_ARB_RR_EN
  logic [TEXT_IDX_W-1:0] ptr_q;

  // Pointer moves to the slot after the last winner
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      ptr_q <= '0;
    end else if (pick_any) begin
      if (pick_idx == TEXT_IDX_W'(NUM_REQ - 1))
        ptr_q <= '0;
      else
        ptr_q <= pick_idx + 1'b1;
    end
  end

  assign start = ptr_q;
`else
  assign start = '0;
`endif

  assign pick_addr =
    req_addr_in[int'(pick_idx)*ADDR_WIDTH +: ADDR_WIDTH];

  // Two or more bits set: clearing the lowest leaves something
  assign multi =
    |(req_valid_in & (req_valid_in - NUM_REQ'(1)));

  // Register winner; address holds on idle to keep the ROM quiet
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      grant_q <= '0;
      idx_q   <= '0;
      addr_q  <= '0;
    end else begin
      grant_q <= pick_oh;
      if (pick_any) begin
        idx_q  <= pick_idx;
        addr_q <= pick_addr;
      end
    end
  end

  // Tag pipeline matches ROM latency behind the registered grant
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      for (int i = 0; i < ROM_LATENCY; i++)
        tag_q[i] <= '0;
    end else begin
      tag_q[0] <= '{valid: |grant_q, index: idx_q};
      for (int i = 1; i < ROM_LATENCY; i++)
        tag_q[i] <= tag_q[i-1];
    end
  end

  assign last = tag_q[ROM_LATENCY-1];

  // Route ROM data to the tagged requester; other bits hold
  always_comb begin
    rsp_valid_d = '0;
    rsp_data_d  = rsp_q;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (last.valid && last.index == TEXT_IDX_W'(i)) begin
        rsp_valid_d[i] = 1'b1;
        rsp_data_d[i]  = rom_data_in;
      end
    end
  end

  // Hold each requester's last pixel
  always_ff @(posedge clk_in) begin
    if (rst_in) rsp_q <= '0;
    else        rsp_q <= rsp_data_d;
  end

  // Saturating count of contended cycles
  always_ff @(posedge clk_in) begin
    if (rst_in)
      cnt_q <= '0;
    else if (multi && cnt_q != '1)
      cnt_q <= cnt_q + 1'b1;
  end

  assign grant_out          = grant_q;
  assign rom_addr_out       = addr_q;
  assign rsp_valid_out      = rsp_valid_d;
  assign rsp_data_out       = rsp_data_d;
  assign conflict_count_out = cnt_q;

endmodule

// File: tb/tb_text_rom_arbiter.sv
// Scoreboard bench for text_rom_arbiter against a behavioural model.
// Tracks TEXT_ARB_RR_EN to pick the arbitration rule of the model.
module tb_text_rom_arbiter;

  localparam int N   = 4;
  localparam int AW  = 15;
  localparam int LAT = 2;
  localparam int CW  = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [N-1:0]  req_v = '0;
  logic [N*AW-1:0] req_a = '0;
  logic [N-1:0]  grant, grant_s;
  logic [AW-1:0] raddr, raddr_s;
  logic          rom_d;
  logic [N-1:0]  rv, rd, rv_s, rd_s;
  logic [CW-1:0] cnt;
  logic [3:0]    cnt_s;

  bit mem [0:(1<<AW)-1];
  bit rpipe [LAT];

  always #5 clk = ~clk;

  int pe = 0;
  always @(posedge clk) pe <= pe + 1;

  always @(posedge clk) begin
    rpipe[0] <= mem[raddr];
    for (int i = 1; i < LAT; i++) rpipe[i] <= rpipe[i-1];
  end
  assign rom_d = rpipe[LAT-1];

  text_rom_arbiter #(
    .NUM_REQ(N), .ADDR_WIDTH(AW), .ROM_LATENCY(LAT), .CNT_WIDTH(CW)
  ) dut (
    .clk_in(clk), .rst_in(rst),
    .req_valid_in(req_v), .req_addr_in(req_a),
    .grant_out(grant), .rom_addr_out(raddr),
    .rom_data_in(rom_d),
    .rsp_valid_out(rv), .rsp_data_out(rd),
    .conflict_count_out(cnt)
  );

  text_rom_arbiter #(
    .NUM_REQ(N), .ADDR_WIDTH(AW), .ROM_LATENCY(LAT), .CNT_WIDTH(4)
  ) dut_sat (
    .clk_in(clk), .rst_in(rst),
    .req_valid_in(req_v), .req_addr_in(req_a),
    .grant_out(grant_s), .rom_addr_out(raddr_s),
    .rom_data_in(rom_d),
    .rsp_valid_out(rv_s), .rsp_data_out(rd_s),
    .conflict_count_out(cnt_s)
  );

  typedef struct {
    int           cyc;
    bit           rst;
    logic [N-1:0] g;
    logic [AW-1:0] a;
    int           cnt;
  } exp_t;

  typedef struct {
    int due;
    int idx;
    bit d;
  } rsp_t;

  exp_t expq[$];
  rsp_t rspq[$];

  int            p = 0;
  logic [AW-1:0] m_addr = '0;
  int            m_cnt = 0;
  int            vecs = 0;
  int            errs = 0;
  bit            mdata [N];

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] expv);
    vecs++;
    if (act !== expv) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d",
               nm, act, expv, pe);
    end
  endtask

  function automatic logic [N*AW-1:0] slot(input int i,
                                           input logic [AW-1:0] ad);
    logic [N*AW-1:0] r;
    r = '0;
    r[i*AW +: AW] = ad;
    return r;
  endfunction

  // Drive one cycle and push what the spec says must follow
  task automatic step(input bit r, input logic [N-1:0] v,
                      input logic [N*AW-1:0] a);
    exp_t e;
    int   w;
    @(negedge clk);
    #1;
    rst   = r;
    req_v = v;
    req_a = a;
    e.cyc = pe + 1;
    e.rst = r;
    e.g   = '0;
    if (r) begin
      p      = 0;
      m_addr = '0;
      m_cnt  = 0;
      rspq.delete();
    end else begin
      w = -1;
      for (int k = 0; k < N; k++) begin
        int j;
        j = (p + k) % N;
        if (w < 0 && v[j]) w = j;
      end
      if (w >= 0) begin
        e.g[w] = 1'b1;
        m_addr = a[w*AW +: AW];
        rspq.push_back('{e.cyc + LAT, w, mem[m_addr]});
`ifdef TEXT_ARB_RR_EN
        p = (w + 1) % N;
`endif
      end
      if ($countones(v) >= 2 && m_cnt < (1 << CW) - 1) m_cnt++;
    end
    e.a   = m_addr;
    e.cnt = m_cnt;
    expq.push_back(e);
  endtask

  // Monitor: compare every cycle that has an expectation queued
  initial begin
    exp_t e;
    rsp_t r;
    logic [N-1:0] ev, ed;
    forever begin
      @(negedge clk);
      if (expq.size() > 0 && expq[0].cyc == pe) begin
        e = expq.pop_front();
        if (e.rst) mdata = '{default: 0};
        chk("grant", 64'(grant), 64'(e.g));
        chk("rom_addr", 64'(raddr), 64'(e.a));
        chk("conflicts", 64'(cnt), 64'(e.cnt));
        chk("conflicts_sat", 64'(cnt_s),
            64'((e.cnt > 15) ? 15 : e.cnt));
        ev = '0;
        if (rspq.size() > 0 && rspq[0].due == pe) begin
          r = rspq.pop_front();
          ev[r.idx] = 1'b1;
          mdata[r.idx] = r.d;
        end
        for (int i = 0; i < N; i++) ed[i] = mdata[i];
        chk("rsp_valid", 64'(rv), 64'(ev));
        chk("rsp_data", 64'(rd), 64'(ed));
      end
    end
  end

  initial begin
    logic [N*AW-1:0] a;
    for (int i = 0; i < (1 << AW); i++) mem[i] = bit'($urandom);
    mem[0]      = 1'b1;
    mem['h123]  = 1'b1;

    step(1'b1, '0, '0);
    step(1'b1, '0, '0);

    // single requester, address 0x123
    step(1'b0, 4'b0001, slot(0, 15'h0123));
    repeat (4) step(1'b0, '0, '0);

    // two-way contention held four cycles
    a = slot(1, 15'h0011) | slot(3, 15'h0033);
    repeat (4) step(1'b0, 4'b1010, a);
    repeat (4) step(1'b0, '0, '0);

    // address zero is a real read
    step(1'b0, 4'b0100, slot(2, 15'h0000));
    repeat (4) step(1'b0, '0, '0);

    // reset two cycles after the grant
    step(1'b0, 4'b0001, slot(0, 15'h0123));
    step(1'b0, '0, '0);
    step(1'b1, '0, '0);
    repeat (4) step(1'b0, '0, '0);

    // counter saturation
    step(1'b1, '0, '0);
    repeat (20) begin
      a = (N*AW)'({$urandom, $urandom});
      step(1'b0, 4'b1111, a);
    end
    repeat (4) step(1'b0, '0, '0);

    // idle hold after address 0xAA
    step(1'b0, 4'b0010, slot(1, 15'h00AA));
    repeat (6) step(1'b0, '0, '0);

    // randomized traffic with occasional reset
    step(1'b1, '0, '0);
    repeat (3000) begin
      a = (N*AW)'({$urandom, $urandom});
      step(($urandom_range(0, 99) == 0),
           N'($urandom & $urandom_range(0, 15)), a);
    end
    repeat (LAT + 4) step(1'b0, '0, '0);
    @(negedge clk);
    @(negedge clk);
    chk("drain_exp", 64'(expq.size()), 64'(0));
    chk("drain_rsp", 64'(rspq.size()), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/text_rom_arbiter.md
# text_rom_arbiter

- Shares one port of a glyph/text bitmap ROM (1-bit pixel data) among up to `NUM_REQ` on-screen text renderers.
- Replaces ad-hoc address OR-ing with explicit request/grant arbitration, which cannot tell a granted address of 0 from an idle port.
- Returns each ROM pixel to the requester that issued the address, using a latency-matched tag pipeline.
- Sits between the per-word text renderers and one BRAM port, in the pixel clock domain.

## Interface
Parameters:
- `NUM_REQ`, 4: number of requesters, 2..8.
- `ADDR_WIDTH`, 15: ROM address width.
- `ROM_LATENCY`, 2: cycles from `rom_addr_out` change to valid `rom_data_in`, ≥1.
- `CNT_WIDTH`, 16: conflict counter width.

Ports:
- `clk_in`  input  1: pixel clock.
- `rst_in`  input  1: synchronous, active-high reset.
- `req_valid_in`  input  NUM_REQ: bit i is high while requester i wants a ROM read.
- `req_addr_in`  input  NUM_REQ*ADDR_WIDTH: requester i's address occupies bits [i*ADDR_WIDTH +: ADDR_WIDTH].
- `grant_out`  output  NUM_REQ: registered one-hot grant; all zero when idle.
- `rom_addr_out`  output  ADDR_WIDTH: registered address to the ROM port.
- `rom_data_in`  input  1: ROM read data.
- `rsp_valid_out`  output  NUM_REQ: one-cycle pulse when requester i's data is on `rsp_data_out[i]`.
- `rsp_data_out`  output  NUM_REQ: per-requester pixel bit, held until the next response to that requester.
- `conflict_count_out`  output  CNT_WIDTH: saturating count of cycles in which more than one request was pending.

## Operation
- Each cycle, the picker selects at most one winner among the asserted `req_valid_in` bits.
- Winner's address and one-hot index are registered into `rom_addr_out` / `grant_out`.
- Losers are not buffered. A requester that still wants data keeps `req_valid_in` asserted and is re-arbitrated the next cycle.
- Tag pipeline: `ROM_LATENCY` stages, each holding {valid, index}.
  - Stage 0 is loaded from the registered grant.
  - At the last stage, if valid, `rsp_data_out[index]` is set to `rom_data_in` and `rsp_valid_out[index]` pulses.
- Idle cycle (no requests):
  - `grant_out` = 0.
  - `rom_addr_out` holds its previous value; no ROM toggling.
  - An invalid tag is inserted into the pipeline.
- Conflicts:
  - `conflict_count_out` increments on any cycle with popcount(`req_valid_in`) ≥ 2.
  - It saturates at all-ones and never wraps.
- Reset:
  - `grant_out`, `rom_addr_out`, `rsp_valid_out`, `rsp_data_out` and `conflict_count_out` all go to 0.
  - All tag stages are invalidated and the round-robin pointer goes to 0.
  - Reset mid-operation discards in-flight reads: no `rsp_valid_out` pulse for any read issued before reset, even if ROM data arrives after it.
- Simultaneous events:
  - A new grant and a response to the same requester in one cycle are independent.
  - A response updates only its own index; other `rsp_data_out` bits hold.

## Timing
- Request sampled at cycle T.
- `grant_out` and `rom_addr_out` are valid at T+1.
- `rsp_valid_out` and `rsp_data_out` are valid at T+1+ROM_LATENCY. Total latency is 3 cycles at the default.
- Throughput is one read per cycle when any request is pending.
- Renderers must advance their pixel-output stage by 1+ROM_LATENCY relative to address generation.

## Configuration
- `TEXT_ARB_RR_EN` defined: round-robin arbitration.
  - The search starts at pointer p. After granting index i, p becomes (i+1) mod NUM_REQ, wrapping correctly for non-power-of-2 NUM_REQ.
  - The pointer is unchanged on idle cycles.
- `TEXT_ARB_RR_EN` undefined: fixed priority, lowest index wins; the pointer logic is absent.
- All other behaviour is identical in both builds.

## Structure
- Shared package `text_pkg` holds:
  - ROM latency constant `TEXT_ROM_LATENCY = 2`.
  - Word-index constants for each ROM image (score/level/lines/next/hold; resume/quit/play/again; start/paused/game_over).
  - A `text_tag_t` struct {valid, index}.
- One sub-module, `arb_pick`: combinational NUM_REQ-wide priority picker taking a start pointer and returning a one-hot winner plus the encoded index. The fixed-priority build ties the start pointer to 0.

## Test plan
1. Single requester: `req_valid_in`=4'b0001 with address 15'h0123 at T, ROM model returns 1.
   - Required: `grant_out`=0001 and `rom_addr_out`=0123 at T+1.
   - Required: `rsp_valid_out`=0001 and `rsp_data_out[0]`=1 at T+3.
2. Contention: `req_valid_in`=4'b1010 held for 4 cycles, with `TEXT_ARB_RR_EN` defined.
   - Required: grants alternate 0010, 1000, 0010, 1000.
   - Required: `conflict_count_out` advances 0→4.
   - Without the macro: 0010 granted in all 4 cycles.
3. Address 0 read: requester 2 reads address 0, where the ROM holds 1.
   - Required: `rsp_valid_out[2]` pulses and `rsp_data_out[2]`=1, proving address 0 is a valid read.
4. Reset mid-flight: grant issued at T, `rst_in` high at T+2.
   - Required: no `rsp_valid_out` pulse at T+3.
   - Required: all outputs 0 the cycle after reset.
5. Saturation: with CNT_WIDTH=4, 20 conflicting cycles.
   - Required: `conflict_count_out` stays at 4'hF.
6. Idle hold: requests drop after address 15'h00AA.
   - Required: `rom_addr_out` stays 00AA, `grant_out`=0, and no responses after the pipeline drains.
